// File: rtl/axi_wr_stream_bridge_pkg.sv
// ----------------------------------------------------------------------------
// axi_wr_stream_bridge_pkg
// Shared types and constants for the AXI write-to-stream bridge.
//   - AXI field typedefs (address, data, strobe, id, burst length)
//   - bridgeState_e : controller states
//   - strBeatSt     : one buffered stream beat
//   - AXI response and burst encodings
//   - beat_addr()   : per-beat destination address
// Optional feature macro: AXI_WR_STREAM_BRIDGE_TUSER_BEAT_EN
//   When defined, strBeatSt carries the 8-bit beat index. The bridge then
//   drives it on tuser.
// ----------------------------------------------------------------------------
package axi_wr_stream_bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;

  typedef logic [ADDR_W-1:0] axiAddrSt;
  typedef logic [DATA_W-1:0] axiDataSt;
  typedef logic [STRB_W-1:0] axiStrobeSt;
  typedef logic [ID_W-1:0]   axiIdSt;
  typedef logic [LEN_W-1:0]  axiLenSt;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } bridgeState_e;

  typedef struct packed {
    axiDataSt   tdata;
    axiStrobeSt tstrb;
    axiStrobeSt tkeep;
    logic       tlast;
    axiAddrSt   tid;
    axiAddrSt   tdest;
`ifdef AXI_WR_STREAM_BRIDGE_TUSER_BEAT_EN
    axiLenSt    beat;
`endif
  } strBeatSt;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  // FIXED repeats the base address. Every other burst code advances by one
  // 32-bit word per beat. The reserved codes are flagged as errors elsewhere.
  // Addition wraps modulo 2^32.
  function automatic axiAddrSt beat_addr(input axiAddrSt base,
                                         input logic [1:0] burst,
                                         input axiLenSt cnt);
    if (burst == AXI_BURST_FIXED) return base;
    return base + {{(ADDR_W-LEN_W-2){1'b0}}, cnt, 2'b00};
  endfunction

endpackage

// File: rtl/axi_wr_stream_bridge_fifo.sv
// ----------------------------------------------------------------------------
// axi_wr_stream_fifo
// Generic synchronous FIFO of strBeatSt entries with a registered output
// path and no write-through bypass.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_push, i_data  write request and entry
//   i_pop           read request; the head entry is consumed
//   o_data          head entry, valid while !o_empty
//   o_full, o_empty status derived from the registered occupancy count
// Parameter FIFO_DEPTH: power of two, >= 2.
// ----------------------------------------------------------------------------
module axi_wr_stream_fifo
  import axi_wr_stream_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  strBeatSt i_data,
  input  logic     i_pop,
  output strBeatSt o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  strBeatSt         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);

  // A push is allowed when the FIFO is full if a pop happens in the same cycle.
  // The head is read before the clock edge overwrites that slot.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage holds data only. The pointers and count alone decide validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/axi_wr_stream_bridge.sv
// ----------------------------------------------------------------------------
// axi_wr_stream_bridge
// AXI write slave that re-emits every accepted W beat as an AXI4-Stream beat.
// The bridge holds one burst in flight. Beats are buffered in
// axi_wr_stream_fifo. The B response is returned once the burst's last beat
// is buffered, so it does not wait for the stream to drain.
// Ports:
//   clk, rst                                clock, asynchronous active-high reset
//   i_aw* / o_awready                       AW channel (id, addr, len, burst)
//   i_w*  / o_wready                        W channel (id, data, strobe, last)
//   o_bvalid, i_bready, o_bid, o_bresp      B channel
//   o_tvalid, i_tready, o_t*                stream master toward the consumer
// Parameter FIFO_DEPTH: stream buffer entries (power of two, >= 2).
// Optional feature macro: AXI_WR_STREAM_BRIDGE_TUSER_BEAT_EN
//   defined   -> tuser = beat index within the burst
//   undefined -> tuser = 0 and the index is not stored
// ----------------------------------------------------------------------------
module axi_wr_stream_bridge
  import axi_wr_stream_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  // AW channel
  input  logic       i_awvalid,
  output logic       o_awready,
  input  axiIdSt     i_awid,
  input  axiAddrSt   i_awaddr,
  input  axiLenSt    i_awlen,
  input  logic [1:0] i_awburst,
  // W channel
  input  logic       i_wvalid,
  output logic       o_wready,
  input  axiIdSt     i_wid,
  input  axiDataSt   i_wdata,
  input  axiStrobeSt i_wstrb,
  input  logic       i_wlast,
  // B channel
  output logic       o_bvalid,
  input  logic       i_bready,
  output axiIdSt     o_bid,
  output logic [1:0] o_bresp,
  // Stream master
  output logic       o_tvalid,
  input  logic       i_tready,
  output axiDataSt   o_tdata,
  output axiStrobeSt o_tstrb,
  output axiStrobeSt o_tkeep,
  output logic       o_tlast,
  output axiAddrSt   o_tid,
  output axiAddrSt   o_tdest,
  output axiAddrSt   o_tuser
);

  bridgeState_e r_state;
  bridgeState_e w_state_nxt;

  axiIdSt     r_awid;
  axiAddrSt   r_awaddr;
  axiLenSt    r_awlen;
  logic [1:0] r_awburst;
  axiLenSt    r_cnt;
  logic       r_err;

  logic       w_awready;
  logic       w_wready;
  logic       w_bvalid;
  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_last_beat;
  logic       w_beat_err;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  strBeatSt   w_push_beat;
  strBeatSt   w_head;

  // Controller state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_last_beat = (r_cnt == r_awlen);

  always_comb begin
    w_state_nxt = r_state;
    w_awready   = 1'b0;
    w_wready    = 1'b0;
    w_bvalid    = 1'b0;
    case (r_state)
      IDLE: begin
        w_awready = 1'b1;
        if (i_awvalid) w_state_nxt = DATA;
      end
      DATA: begin
        w_wready = ~w_full;
        // The burst length comes only from awlen. wlast is only checked for errors.
        if (i_wvalid && !w_full && w_last_beat) w_state_nxt = RESP;
      end
      RESP: begin
        w_bvalid = 1'b1;
        if (i_bready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_aw_hs = w_awready & i_awvalid;
  assign w_w_hs  = w_wready & i_wvalid;

  // The reserved burst codes 10/11 set the error flag.
  // Their addresses still advance as INCR.
  assign w_beat_err = (i_wid != r_awid) | (i_wlast != w_last_beat) | r_awburst[1];

  // Burst progress: beat counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_aw_hs) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_w_hs) begin
      r_cnt <= r_cnt + LEN_W'(1);
      r_err <= r_err | w_beat_err;
    end
  end

  // Captured AW fields are used only while a burst is active.
  // They are not reset.
  always_ff @(posedge clk) begin
    if (w_aw_hs) begin
      r_awid    <= i_awid;
      r_awaddr  <= i_awaddr;
      r_awlen   <= i_awlen;
      r_awburst <= i_awburst;
    end
  end

  always_comb begin
    w_push_beat       = '0;
    w_push_beat.tdata = i_wdata;
    w_push_beat.tstrb = i_wstrb;
    w_push_beat.tkeep = i_wstrb;
    w_push_beat.tlast = w_last_beat;
    w_push_beat.tid   = {{(ADDR_W-ID_W){1'b0}}, r_awid};
    w_push_beat.tdest = beat_addr(r_awaddr, r_awburst, r_cnt);
`ifdef AXI_WR_STREAM_BRIDGE_TUSER_BEAT_EN
    w_push_beat.beat  = r_cnt;
`endif
  end

  // Stream buffer
  axi_wr_stream_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_w_hs),
    .i_data  (w_push_beat),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop = ~w_empty & i_tready;

  // The state register resets to IDLE. rst is gated here so that awready
  // stays low while reset is asserted.
  assign o_awready = w_awready & ~rst;
  assign o_wready  = w_wready;
  assign o_bvalid  = w_bvalid;
  assign o_bid     = w_bvalid ? r_awid : '0;
  assign o_bresp   = w_bvalid ? (r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY) : 2'b00;

  // FIFO storage is not reset, so the stream fields are forced to zero
  // whenever no beat is presented.
  assign o_tvalid = ~w_empty;
  assign o_tdata  = w_empty ? '0   : w_head.tdata;
  assign o_tstrb  = w_empty ? '0   : w_head.tstrb;
  assign o_tkeep  = w_empty ? '0   : w_head.tkeep;
  assign o_tlast  = w_empty ? 1'b0 : w_head.tlast;
  assign o_tid    = w_empty ? '0   : w_head.tid;
  assign o_tdest  = w_empty ? '0   : w_head.tdest;
`ifdef AXI_WR_STREAM_BRIDGE_TUSER_BEAT_EN
  assign o_tuser  = w_empty ? '0   : {{(ADDR_W-LEN_W){1'b0}}, w_head.beat};
`else
  assign o_tuser  = '0;
`endif

endmodule

// File: tb/tb_axi_wr_stream_bridge.sv
// ----------------------------------------------------------------------------
// tb_axi_wr_stream_bridge
// Self-checking bench for axi_wr_stream_bridge.
// A queue of expected stream beats is built from the AXI rules as each W beat
// is accepted. The B response is predicted from the burst's error conditions.
// Optional feature macro: AXI_WR_STREAM_BRIDGE_TUSER_BEAT_EN selects the
// expected tuser values.
// ----------------------------------------------------------------------------
module tb_axi_wr_stream_bridge;

  logic        clk;
  logic        rst;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        tvalid, tready;
  logic [31:0] tdata;
  logic [3:0]  tstrb, tkeep;
  logic        tlast;
  logic [31:0] tid, tdest, tuser;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axi_wr_stream_bridge #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .i_awvalid(awvalid), .o_awready(awready), .i_awid(awid), .i_awaddr(awaddr),
    .i_awlen(awlen), .i_awburst(awburst),
    .i_wvalid(wvalid), .o_wready(wready), .i_wid(wid), .i_wdata(wdata),
    .i_wstrb(wstrb), .i_wlast(wlast),
    .o_bvalid(bvalid), .i_bready(bready), .o_bid(bid), .o_bresp(bresp),
    .o_tvalid(tvalid), .i_tready(tready), .o_tdata(tdata), .o_tstrb(tstrb),
    .o_tkeep(tkeep), .o_tlast(tlast), .o_tid(tid), .o_tdest(tdest), .o_tuser(tuser)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [31:0] tid;
    logic [31:0] tdest;
    logic [31:0] tuser;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tready_mode = 1;   // 0: hold low, 1: hold high, 2: random

  // Reference state of the burst in flight
  logic [3:0]  m_id;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [1:0]  m_burst;
  logic        m_err;
  int          m_beat;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // tready driver
  initial begin
    tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tready_mode)
        0:       tready = 1'b0;
        1:       tready = 1'b1;
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Stream monitor: a beat is consumed on the coming edge when tvalid&&tready
  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      if (q.size() == 0) begin
        check("stray_beat", 160'(q.size()), 160'(1));
      end else begin
        mon_e = q.pop_front();
        check("stream_beat", 160'({tdata, tstrb, tkeep, tlast, tid, tdest, tuser}), 160'(mon_e));
      end
    end
  end

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input logic [1:0] burst);
    logic ok;
    ok = 1'b0;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awburst = burst;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk); ok = awready;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    check("aw_handshake", 160'(ok), 160'(1));
    m_id = id; m_addr = addr; m_len = len; m_burst = burst;
    m_err = burst[1];
    m_beat = 0;
  endtask

  task automatic do_beat(input logic wid_bad, input logic wlast_bad);
    logic ok;
    logic lastexp;
    exp_t e;
    ok = 1'b0;
    lastexp = (m_beat == int'(m_len));
    wvalid = 1'b1;
    wdata  = $urandom;
    wstrb  = 4'($urandom_range(0, 15));
    wid    = wid_bad ? (m_id ^ 4'h1) : m_id;
    wlast  = wlast_bad ? ~lastexp : lastexp;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk); ok = wready;
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    check("w_handshake", 160'(ok), 160'(1));
    if (ok) begin
      e.data  = wdata;
      e.strb  = wstrb;
      e.keep  = wstrb;
      e.last  = lastexp;
      e.tid   = {28'd0, m_id};
      e.tdest = (m_burst == 2'b00) ? m_addr : m_addr + 32'(m_beat * 4);
`ifdef AXI_WR_STREAM_BRIDGE_TUSER_BEAT_EN
      e.tuser = 32'(m_beat);
`else
      e.tuser = 32'd0;
`endif
      q.push_back(e);
      m_err = m_err | wid_bad | wlast_bad;
      m_beat++;
    end
  endtask

  task automatic do_resp(input logic check_lat);
    @(negedge clk);
    if (check_lat) check("b_latency", 160'(bvalid), 160'(1));
    for (int c = 0; c < 400 && !bvalid; c++) @(negedge clk);
    check("b_valid", 160'(bvalid), 160'(1));
    check("b_fields", 160'({bid, bresp}), 160'({m_id, (m_err ? 2'b10 : 2'b00)}));
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 500 && q.size() != 0; c++) @(posedge clk);
    #1;
    check("drain", 160'(q.size()), 160'(0));
  endtask

  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int wid_err_beat,
                           input int wlast_err_beat, input logic gaps);
    do_aw(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      do_beat(i == wid_err_beat, i == wlast_err_beat);
    end
    do_resp(1'b1);
  endtask

  initial begin
    logic [3:0]  r_id;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [1:0]  r_burst;
    int          r_we, r_wl;

    rst = 1'b1;
    awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awburst = '0;
    wvalid = 1'b0; wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0;
    bready = 1'b0;
    tready_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          160'({awready, wready, bvalid, tvalid, tdata, tlast, tid, tdest, tuser, bid, bresp}), 160'(0));
    rst = 1'b0;
    @(negedge clk);
    check("awready_after_reset", 160'(awready), 160'(1));
    @(posedge clk); #1;

    // Single INCR burst
    do_aw(4'd5, 32'h0000_1000, 8'd3, 2'b01);
    @(negedge clk);
    check("wready_latency", 160'(wready), 160'(1));
    check("awready_low_in_data", 160'(awready), 160'(0));
    @(posedge clk); #1;
    repeat (4) do_beat(1'b0, 1'b0);
    do_resp(1'b1);
    wait_drain();

    // FIXED burst with stream backpressure
    tready_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    do_aw(4'd3, 32'h0000_2000, 8'd7, 2'b00);
    repeat (4) do_beat(1'b0, 1'b0);
    @(negedge clk);
    check("bp_wready_low", 160'(wready), 160'(0));
    repeat (3) @(negedge clk);
    check("bp_hold", 160'({wready, bvalid, tvalid}), 160'(3'b001));
    @(posedge clk); #1;
    tready_mode = 1;
    repeat (4) do_beat(1'b0, 1'b0);
    do_resp(1'b1);
    wait_drain();

    // Early wlast on beat 1 of a 3-beat burst, then a wid mismatch
    run_burst(4'd7, 32'h0000_4000, 8'd2, 2'b01, -1, 1, 1'b0);
    wait_drain();
    run_burst(4'd9, 32'h0000_5000, 8'd1, 2'b01, 0, -1, 1'b0);
    wait_drain();

    // Address wrap past 2^32
    run_burst(4'd1, 32'hFFFF_FFFC, 8'd1, 2'b01, -1, -1, 1'b0);
    wait_drain();

    // Reserved burst code: addresses advance as INCR, response is SLVERR
    run_burst(4'd2, 32'h0000_6000, 8'd3, 2'b10, -1, -1, 1'b0);
    wait_drain();

    // Reset in the middle of a burst
    tready_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    do_aw(4'd4, 32'h0000_7000, 8'd3, 2'b01);
    do_beat(1'b0, 1'b0);
    do_beat(1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", 160'({tvalid, bvalid, awready, wready}), 160'(0));
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("awready_after_mid_reset", 160'(awready), 160'(1));
    @(posedge clk); #1;
    tready_mode = 1;
    run_burst(4'd6, 32'h0000_8000, 8'd3, 2'b01, -1, -1, 1'b0);
    wait_drain();

    // Randomized bursts with random stream backpressure and W gaps
    tready_mode = 2;
    for (int n = 0; n < 12; n++) begin
      r_id    = 4'($urandom_range(0, 15));
      r_addr  = $urandom;
      r_addr[1:0] = 2'b00;
      r_len   = 8'($urandom_range(0, 7));
      r_burst = 2'($urandom_range(0, 3));
      r_we    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(r_len))) : -1;
      r_wl    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(r_len))) : -1;
      run_burst(r_id, r_addr, r_len, r_burst, r_we, r_wl, 1'b1);
    end
    tready_mode = 1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
